quad_step_gen: RTL

- Quadrature step generator: the transmit-side counterpart of the team's debounced A/B rotary decoder.
- Converts step commands (up/down) into one full A/B Gray-code detent cycle per step.
- Optionally injects contact bounce on each edge.
- Keeps a 0..9 saturating position mirror that must equal the decoder's count when the two are looped back.
- Used as an on-chip stimulus source for the decoder and as a drive for external quadrature inputs.

---
 rtl/quad_step_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/quad_step_gen.sv
// Quadrature step generator.
// Turns up/down step commands into one full A/B Gray-code detent cycle per
// step, with optional contact-bounce injection on each edge. A saturating
// 0..MAXN position mirror tracks what a looped-back decoder should count.
//
// Ports:
//   clkin      - system clock, rising edge
//   rst        - asynchronous active-low reset
//   step_valid - step request
//   step_dir   - 0 = up, 1 = down; latched at acceptance
//   step_ready - request can be accepted (IDLE only), registered
//   bounce_en  - enable bounce injection; latched at acceptance
//   A, B       - quadrature phases, registered
//   done       - one-cycle pulse on the first IDLE cycle after a step
//   pos        - position mirror, 0..MAXN, registered
module quad_step_gen #(
    parameter int unsigned PHASE_TICKS = 16,
    parameter int unsigned BOUNCE_CYC  = 3,
    parameter logic [3:0]  MAXN        = 4'd9
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       step_valid,
    input  logic       step_dir,
    output logic       step_ready,
    input  logic       bounce_en,
    output logic       A,
    output logic       B,
    output logic       done,
    output logic [3:0] pos
);

    localparam int unsigned TICK_W     = 8;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(PHASE_TICKS - 1);
    localparam logic [TICK_W-1:0] BOUNCE_LEN = TICK_W'(BOUNCE_CYC);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4
    } state_t;

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick, tick_next;
    logic                dir_q, dir_next;
    logic                bnc_q, bnc_next;
    logic [3:0]          pos_next;
    logic                done_next;
    logic                ready_next;
    logic [1:0]          ab_next;

    // Steady {A,B} value of a state for the given direction.
    function automatic logic [1:0] phase_ab(input state_t s, input logic d);
        logic [1:0] v;
        v = 2'b00;
        case (s)
            PH1:     v = d ? 2'b01 : 2'b10;
            PH2:     v = 2'b11;
            PH3:     v = d ? 2'b10 : 2'b01;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // State whose {A,B} value precedes s; consecutive phases differ in one
    // line only, so showing the previous value is exactly "old" on that line.
    function automatic state_t prev_state(input state_t s);
        state_t p;
        p = IDLE;
        case (s)
            PH2:     p = PH1;
            PH3:     p = PH2;
            PH4:     p = PH3;
            default: p = IDLE;
        endcase
        return p;
    endfunction

    // State and output registers.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tick       <= '0;
            dir_q      <= 1'b0;
            bnc_q      <= 1'b0;
            pos        <= '0;
            done       <= 1'b0;
            step_ready <= 1'b1;
            A          <= 1'b0;
            B          <= 1'b0;
        end else begin
            state      <= state_next;
            tick       <= tick_next;
            dir_q      <= dir_next;
            bnc_q      <= bnc_next;
            pos        <= pos_next;
            done       <= done_next;
            step_ready <= ready_next;
            A          <= ab_next[1];
            B          <= ab_next[0];
        end
    end

    // Next-state, tick, position and A/B output logic.
    always_comb begin
        state_next = state;
        tick_next  = tick + TICK_W'(1);
        dir_next   = dir_q;
        bnc_next   = bnc_q;
        pos_next   = pos;
        done_next  = 1'b0;
        ab_next    = 2'b00;
        ready_next = 1'b0;

        case (state)
            IDLE: begin
                tick_next = '0;
                if (step_valid && step_ready) begin
                    state_next = PH1;
                    dir_next   = step_dir;
                    bnc_next   = bounce_en;
                    // Up: A rises on PH1 entry.
                    if (!step_dir && (pos < MAXN)) begin
                        pos_next = pos + 4'd1;
                    end
                end
            end
            default: begin
                if (tick == TICK_LAST) begin
                    tick_next = '0;
                    case (state)
                        PH1: begin
                            state_next = PH2;
                            // Down: A rises on PH2 entry.
                            if (dir_q && (pos != 4'd0)) begin
                                pos_next = pos - 4'd1;
                            end
                        end
                        PH2:     state_next = PH3;
                        PH3:     state_next = PH4;
                        default: begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        ready_next = (state_next == IDLE);

        // Bounce: odd tick counts inside the bounce window show the old value.
        ab_next = phase_ab(state_next, dir_next);
        if (bnc_next && (state_next != IDLE) && (tick_next < BOUNCE_LEN) && tick_next[0]) begin
            ab_next = phase_ab(prev_state(state_next), dir_next);
        end
    end

endmodule
